// File: rtl/eval_scan_ctrl.sv
// eval_scan_ctrl: steps move_index through the generated moves, clears the evaluator per move,
// and keeps the best signed score (max for white, min for black) with a per-move watchdog.
module eval_scan_ctrl #(
    parameter int EVAL_WIDTH    = 32,
    parameter int INDEX_WIDTH   = 8,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [INDEX_WIDTH-1:0]        move_count,
    input  logic                          white_to_move,
    output logic [INDEX_WIDTH-1:0]        move_index,
    output logic                          clear_eval,
    input  logic                          eval_valid,
    input  logic signed [EVAL_WIDTH-1:0]  eval,
    output logic                          busy,
    output logic                          done,
    output logic [INDEX_WIDTH-1:0]        best_index,
    output logic signed [EVAL_WIDTH-1:0]  best_eval,
    output logic                          no_moves,
    output logic                          timeout_error
);
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SETTLE, S_WAIT, S_DONE} state_e;
    localparam logic [INDEX_WIDTH-1:0]   IDX_ONE = 1;
    localparam logic [TIMEOUT_WIDTH-1:0] WD_ONE  = 1;
    state_e                         state_q, state_d;
    logic [INDEX_WIDTH-1:0]         idx_q, idx_d, cnt_q, cnt_d, best_idx_q, best_idx_d;
    logic signed [EVAL_WIDTH-1:0]   best_eval_q, best_eval_d;
    logic                           white_q, white_d, no_moves_q, no_moves_d, timeout_q, timeout_d;
    logic [TIMEOUT_WIDTH-1:0]       wd_q, wd_d;
    logic                           better;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            best_idx_q  <= '0;
            best_eval_q <= '0;
            white_q     <= 1'b0;
            no_moves_q  <= 1'b0;
            timeout_q   <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            best_idx_q  <= best_idx_d;
            best_eval_q <= best_eval_d;
            white_q     <= white_d;
            no_moves_q  <= no_moves_d;
            timeout_q   <= timeout_d;
            wd_q        <= wd_d;
        end
    end
    // Move 0 always loads; later moves need a strict improvement so ties keep the lower index.
    assign better = (idx_q == '0) || (white_q ? (eval > best_eval_q) : (eval < best_eval_q));
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        best_idx_d  = best_idx_q;
        best_eval_d = best_eval_q;
        white_d     = white_q;
        no_moves_d  = no_moves_q;
        timeout_d   = timeout_q;
        wd_d        = wd_q;
        case (state_q)
            S_IDLE: if (start) begin
                cnt_d       = move_count;
                white_d     = white_to_move;
                idx_d       = '0;
                best_idx_d  = '0;
                best_eval_d = '0;
                timeout_d   = 1'b0;
                no_moves_d  = (move_count == '0);
                state_d     = (move_count == '0) ? S_DONE : S_CLEAR;
            end
            S_CLEAR: state_d = S_SETTLE;
            S_SETTLE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: if (eval_valid) begin
                if (better) begin
                    best_idx_d  = idx_q;
                    best_eval_d = eval;
                end
                if (idx_q == cnt_q - IDX_ONE) state_d = S_DONE;
                else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = S_CLEAR;
                end
            end else if (wd_q == '1) begin
                timeout_d = 1'b1;
                state_d   = S_DONE;
            end else wd_d = wd_q + WD_ONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    assign move_index    = idx_q;
    assign clear_eval    = (state_q == S_CLEAR);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign best_index    = best_idx_q;
    assign best_eval     = best_eval_q;
    assign no_moves      = no_moves_q;
    assign timeout_error = timeout_q;
endmodule
